// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status codes and the stat-control state type.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Architectural status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;
    localparam logic [2:0] STMO = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

endpackage

// File: rtl/y86_stat_encode.sv
// Combinational status priority encoder: ADR beats INS beats HLT beats AOK.
module y86_stat_encode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       instr_valid,
    input  logic       imem_error,
    input  logic       dmem_error,
    output logic [2:0] cur_stat
);

    // Priority-ordered status selection for the current cycle
    always_comb begin
        cur_stat = SAOK;
        if (imem_error || dmem_error) begin
            cur_stat = SADR;
        end else if (!instr_valid) begin
            cur_stat = SINS;
        end else if (icode == IHALT) begin
            cur_stat = SHLT;
        end
    end

endmodule

// File: rtl/y86_stat_ctrl.sv
// SEQ status controller: run FSM (IDLE/RUN/STOP), sticky stat, commit gating,
// saturating cycle and retired-instruction counters.
// Optional run-cycle watchdog enabled by defining Y86_STAT_WDOG_EN.
module y86_stat_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    output logic [2:0]       stat,
    output logic             halted,
    output logic             commit_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [2:0]       stat_q, stat_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [2:0]       cur_stat;
    logic             stop_req;

    y86_stat_encode u_encode (
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .cur_stat    (cur_stat)
    );

`ifdef Y86_STAT_WDOG_EN
    localparam logic [CNT_W-1:0] WdogLast = CNT_W'(WDOG_CYCLES - 1);
    logic wdog_hit;

    // Watchdog fires on the last allowed run cycle; zero disables it
    always_comb begin
        wdog_hit = (WDOG_CYCLES != 0) && (cycle_cnt_q == WdogLast);
    end

    // A real fault outranks the timeout
    always_comb begin
        stop_req = (cur_stat != SAOK) || wdog_hit;
    end
`else
    // Only a fault or halt ends a run
    always_comb begin
        stop_req = (cur_stat != SAOK);
    end
`endif

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stat_q      <= SAOK;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (stop_req) state_d = STOP;
            STOP:    if (clear)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status, halt flag and counter updates per state
    always_comb begin
        stat_d      = stat_q;
        halted_d    = halted_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cycle_cnt_d = '0;
                    instr_cnt_d = '0;
                end
            end
            RUN: begin
                if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                // HLT retires; ADR and INS do not
                if ((cur_stat == SAOK || cur_stat == SHLT) && instr_cnt_q != '1) begin
                    instr_cnt_d = instr_cnt_q + CNT_W'(1);
                end
                if (stop_req) begin
                    stat_d   = (cur_stat != SAOK) ? cur_stat : STMO;
                    halted_d = 1'b1;
                end
            end
            STOP: begin
                if (clear) begin
                    stat_d   = SAOK;
                    halted_d = 1'b0;
                end
            end
            default: begin
                stat_d   = SAOK;
                halted_d = 1'b0;
            end
        endcase
    end

    // Outputs; commit is gated combinationally for the current cycle
    always_comb begin
        commit_en = (state_q == RUN) && (cur_stat == SAOK);
        stat      = stat_q;
        halted    = halted_q;
        cycle_cnt = cycle_cnt_q;
        instr_cnt = instr_cnt_q;
    end

endmodule

// File: tb/tb_y86_stat_ctrl.sv
// Scoreboard bench for y86_stat_ctrl. Counters are narrowed to 4 bits so saturation is reachable.
// Build with Y86_STAT_WDOG_EN defined to exercise the watchdog flow instead of the main flow.
module tb_y86_stat_ctrl;
    import y86_pkg::*;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    icode = 4'h6;
    logic          instr_valid = 1'b1;
    logic          imem_error = 1'b0;
    logic          dmem_error = 1'b0;
    logic [2:0]    stat;
    logic          halted;
    logic          commit_en;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] instr_cnt;

    y86_stat_ctrl #(
        .CNT_W       (CW),
        .WDOG_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear       (clear),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .stat        (stat),
        .halted      (halted),
        .commit_en   (commit_en),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       commit;
        logic [2:0] stat;
        logic       halted;
        int         cyc;
        int         ins;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    function automatic void chk(input string name, input int id,
                                input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, required %0d", name, id, act, req);
        end
    endfunction

    // Drive one cycle of inputs and queue the expected commit (this cycle) and registers (after edge)
    task automatic drive(input logic s, input logic c, input logic [3:0] ic, input logic iv,
                         input logic ie, input logic de, input logic ec, input logic [2:0] es,
                         input logic eh, input int ecyc, input int eins);
        exp_t e;
        @(negedge clk);
        start = s; clear = c; icode = ic; instr_valid = iv; imem_error = ie; dmem_error = de;
        e.id = step_id; e.commit = ec; e.stat = es; e.halted = eh; e.cyc = ecyc; e.ins = eins;
        step_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: commit mid-cycle, registered outputs just after the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("commit_en", e.id, 32'(commit_en), 32'(e.commit));
                @(posedge clk);
                #1;
                chk("stat", e.id, 32'(stat), 32'(e.stat));
                chk("halted", e.id, 32'(halted), 32'(e.halted));
                chk("cycle_cnt", e.id, 32'(cycle_cnt), e.cyc);
                chk("instr_cnt", e.id, 32'(instr_cnt), e.ins);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_stat", -1, 32'(stat), 32'(SAOK));
        chk("reset_halted", -1, 32'(halted), 0);
        chk("reset_commit", -1, 32'(commit_en), 0);
        chk("reset_cycle", -1, 32'(cycle_cnt), 0);
        chk("reset_instr", -1, 32'(instr_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef Y86_STAT_WDOG_EN
        // Start, then 5 AOK cycles
        drive(1, 0, 4'h6, 1, 0, 0, 0, SAOK, 0, 0, 0);
        for (int k = 1; k <= 5; k++) drive(0, 0, 4'h6, 1, 0, 0, 1, SAOK, 0, k, k);
        // HLT retires and stops; later dmem errors are ignored in STOP
        drive(0, 0, IHALT, 1, 0, 0, 0, SHLT, 1, 6, 6);
        for (int k = 0; k < 10; k++) drive(0, 0, 4'h6, 1, 0, 1, 0, SHLT, 1, 6, 6);
        // clear returns to IDLE holding counters; start+clear restarts with counters cleared
        drive(0, 1, 4'h6, 1, 0, 0, 0, SAOK, 0, 6, 6);
        drive(1, 1, 4'h6, 1, 0, 0, 0, SAOK, 0, 0, 0);
        // ADR beats INS and HLT, not retired
        drive(0, 0, 4'h6, 1, 0, 0, 1, SAOK, 0, 1, 1);
        drive(0, 0, IHALT, 0, 1, 0, 0, SADR, 1, 2, 1);
        drive(0, 1, 4'h6, 1, 0, 0, 0, SAOK, 0, 2, 1);
        // INS stop; start in STOP and clear in IDLE are ignored
        drive(1, 0, 4'h6, 1, 0, 0, 0, SAOK, 0, 0, 0);
        drive(0, 0, 4'h6, 0, 0, 0, 0, SINS, 1, 1, 0);
        drive(1, 0, 4'h6, 1, 0, 0, 0, SINS, 1, 1, 0);
        drive(0, 1, 4'h6, 1, 0, 0, 0, SAOK, 0, 1, 0);
        drive(0, 1, 4'h6, 1, 0, 0, 0, SAOK, 0, 1, 0);
        // start and clear ignored in RUN
        drive(1, 0, 4'h6, 1, 0, 0, 0, SAOK, 0, 0, 0);
        drive(0, 1, 4'h6, 1, 0, 0, 1, SAOK, 0, 1, 1);
        drive(1, 0, 4'h6, 1, 0, 0, 1, SAOK, 0, 2, 2);
        for (int k = 3; k <= 7; k++) drive(0, 0, 4'h6, 1, 0, 0, 1, SAOK, 0, k, k);
        // Asynchronous reset mid-cycle with cycle_cnt=7
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_stat", -2, 32'(stat), 32'(SAOK));
        chk("async_rst_halted", -2, 32'(halted), 0);
        chk("async_rst_commit", -2, 32'(commit_en), 0);
        chk("async_rst_cycle", -2, 32'(cycle_cnt), 0);
        chk("async_rst_instr", -2, 32'(instr_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Saturation at all-ones, then HLT with saturated counters
        drive(1, 0, 4'h6, 1, 0, 0, 0, SAOK, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            drive(0, 0, 4'h6, 1, 0, 0, 1, SAOK, 0, (k > 15) ? 15 : k, (k > 15) ? 15 : k);
        end
        drive(0, 0, IHALT, 1, 0, 0, 0, SHLT, 1, 15, 15);
`else
        // Watchdog at 4 cycles, all AOK
        drive(1, 0, 4'h6, 1, 0, 0, 0, SAOK, 0, 0, 0);
        for (int k = 1; k <= 3; k++) drive(0, 0, 4'h6, 1, 0, 0, 1, SAOK, 0, k, k);
        drive(0, 0, 4'h6, 1, 0, 0, 1, STMO, 1, 4, 4);
        drive(0, 1, 4'h6, 1, 0, 0, 0, SAOK, 0, 4, 4);
        // Real fault on the watchdog cycle wins
        drive(1, 0, 4'h6, 1, 0, 0, 0, SAOK, 0, 0, 0);
        for (int k = 1; k <= 3; k++) drive(0, 0, 4'h6, 1, 0, 0, 1, SAOK, 0, k, k);
        drive(0, 0, 4'h6, 0, 0, 0, 0, SINS, 1, 4, 3);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", -3, 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/y86_stat_ctrl.md
Name: y86_stat_ctrl

Overview:
- Generates the Y86 architectural status code, `Stat`, for the SEQ processor from per-cycle fetch and memory error indications.
- Gates architectural commits and freezes the machine on HLT, ADR or INS.
- Keeps cycle and retired-instruction counters.
- Sits beside fetch/memory. Its `halted` and `stat` outputs feed the top-level run monitor that ends simulation.

Parameters:
- CNT_W, 32, width of cycle_cnt and instr_cnt.
- WDOG_CYCLES, 1000000, run-cycle limit; used only when Y86_STAT_WDOG_EN is defined.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level or pulse; begins a run when in IDLE
- clear  input  1  acknowledges a stop; returns STOP to IDLE
- icode  input  4  fetched instruction code for the current cycle
- instr_valid  input  1  fetch decoded a legal icode/ifun
- imem_error  input  1  instruction fetch address invalid
- dmem_error  input  1  data memory address invalid in the current cycle
- stat  output  3  registered status: 1=AOK, 2=HLT, 3=ADR, 4=INS, 5=TMO
- halted  output  1  registered; high in STOP
- commit_en  output  1  combinational; permits reg-file, CC, memory-write and PC updates this cycle
- cycle_cnt  output  CNT_W  cycles spent in RUN
- instr_cnt  output  CNT_W  retired instructions

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, stat=1, halted=0, cycle_cnt=0, instr_cnt=0. commit_en is 0 while in reset.
- cur_stat (combinational), evaluated in priority order:
  - imem_error|dmem_error → 3 (ADR);
  - else !instr_valid → 4 (INS);
  - else icode==4'h0 → 2 (HLT);
  - else 1 (AOK).
- commit_en = (state==RUN) && (cur_stat==1). A faulting or halt instruction commits nothing.
- FSM states IDLE, RUN, STOP:
  - IDLE: start=1 at an edge → RUN, and cycle_cnt and instr_cnt clear to 0 at that edge. clear is ignored. start and clear together → start wins.
  - RUN, cur_stat==1: stay in RUN.
  - RUN, cur_stat!=1: at the edge, stat←cur_stat, halted←1, state←STOP. Latency from fault to stat/halted valid is 1 cycle.
  - RUN: start and clear are ignored.
  - STOP: stat is held (sticky). Inputs icode, instr_valid and the error flags are ignored. clear=1 at an edge → IDLE, stat←1, halted←0, counters held for readout. start is ignored.
- Counters in RUN:
  - cycle_cnt increments every cycle, including the faulting/halting cycle.
  - instr_cnt increments when cur_stat is 1 or 2; HLT counts as retired, ADR/INS do not.
  - Both saturate at all-ones with no wrap.
  - Both hold in IDLE and STOP.
- Reset asserted mid-run: immediate return to reset values; no partial update.
- commit_en is glitch-tolerant only with respect to the edge. Consumers sample it at the clk rising edge.

Optional Feature:
Y86_STAT_WDOG_EN.
- Defined: in RUN, if cur_stat==1 at the edge where cycle_cnt==WDOG_CYCLES-1, then stat←5 (TMO), halted←1, state←STOP, and cycle_cnt still increments.
  - A real fault in the same cycle takes priority over TMO.
  - WDOG_CYCLES=0 disables the watchdog.
- Undefined: code 5 is never produced, WDOG_CYCLES is unused, and there is no watchdog logic.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (IHALT=4'h0 … IPOPQ=4'hB);
  - stat constants SAOK=3'd1, SHLT=3'd2, SADR=3'd3, SINS=3'd4, STMO=3'd5;
  - the state enum {IDLE, RUN, STOP}.
- One sub-module, y86_stat_encode: purely combinational cur_stat priority encoder. It is reused by the future PIPE write-back stage.
- FSM, counters and watchdog stay in y86_stat_ctrl.

Test Plan:
1. Reset then start=1 for 1 cycle, then 5 cycles with icode=4'h6, instr_valid=1, no errors → commit_en=1 each cycle, stat=1, cycle_cnt=5, instr_cnt=5.
2. In RUN, present icode=0 → commit_en=0 that cycle; next cycle stat=2, halted=1, instr_cnt incremented by 1. Then 10 cycles with dmem_error=1 → stat stays 2.
3. In RUN, same cycle imem_error=1, instr_valid=0, icode=0 → stat=3 (ADR beats INS and HLT), instr_cnt unchanged.
4. In STOP assert clear → next cycle IDLE, stat=1, halted=0, counters held. Then start and clear together → RUN with counters 0.
5. Assert rst_n=0 asynchronously mid-cycle during RUN with cycle_cnt=7 → outputs return to reset values immediately, before the next clk edge.
6. With Y86_STAT_WDOG_EN and WDOG_CYCLES=4, all AOK → halted after the 4th RUN cycle, stat=5, cycle_cnt=4. Repeat with instr_valid=0 on cycle 4 → stat=4.
